// File: rtl/dbg_bus_arbiter_if.sv
// Request/grant memory bus with a separate response channel.
// A master issues requests; a slave grants them and returns responses.
interface dbg_bus_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dbg_bus_arbiter.sv
// Shares one memory bus between the core load/store unit and the debug transport.
// Debug wins: the core is held and drained, then exactly one debug access runs per request edge.
module dbg_bus_arbiter #(
  parameter int DRAIN_CYCLES = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dbg_req_i,
  input  logic               dbg_we_i,
  input  logic [31:0]        dbg_addr_i,
  input  logic [31:0]        dbg_wdata_i,
  output logic [31:0]        dbg_rdata_o,
  output logic               dbg_done_o,
  output logic               dbg_err_o,
  input  logic               halt_req_i,
  output logic               hold_o,
  dbg_bus_arbiter_if.slave   core,
  dbg_bus_arbiter_if.master  bus
);

  localparam logic [7:0] DRAIN_LAST   = (DRAIN_CYCLES > 1) ? 8'(DRAIN_CYCLES - 1) : 8'd0;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, DRAIN, DBG_REQ, DBG_WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_q;
  logic        outstanding_q, outstanding_d;
  logic        rise;

  assign rise        = dbg_req_i & ~req_q;
  assign hold_o      = halt_req_i | (state_q != IDLE);
  assign dbg_done_o  = (state_q == DONE);
  assign dbg_err_o   = err_q;
  assign dbg_rdata_o = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      req_q         <= 1'b0;
      outstanding_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      req_q         <= dbg_req_i;
      outstanding_q <= outstanding_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    rdata_d       = rdata_q;
    bus.req       = 1'b0;
    bus.we        = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    core.gnt      = 1'b0;
    // Responses only belong to the core while it has a transaction in flight.
    core.rvalid   = outstanding_q & bus.rvalid;
    core.rdata    = outstanding_q ? bus.rdata : '0;

    case (state_q)
      IDLE: begin
        bus.req   = core.req;
        bus.we    = core.we;
        bus.addr  = core.addr;
        bus.wdata = core.wdata;
        core.gnt  = bus.gnt;
        if (rise) begin
          state_d = DRAIN;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      DRAIN: begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        if (cnt_q >= DRAIN_LAST && !outstanding_q) begin
          state_d = DBG_REQ;
          cnt_d   = '0;
        end
      end
      DBG_REQ: begin
        bus.req   = 1'b1;
        bus.we    = dbg_we_i;
        bus.addr  = dbg_addr_i;
        bus.wdata = dbg_wdata_i;
        if (bus.gnt) begin
          state_d = DBG_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DBG_WAIT: begin
        if (bus.rvalid) begin
          state_d = DONE;
          if (!dbg_we_i) rdata_d = bus.rdata;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (!dbg_req_i) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    outstanding_d = outstanding_q;
    if (outstanding_q && bus.rvalid) outstanding_d = 1'b0;
    if (core.req && core.gnt) outstanding_d = 1'b1;
  end

endmodule
